// File: rtl/spi_sensor_responder.sv
// spi_sensor_responder: SPI mode-0 responder emulating the sensor; decodes 16-bit commands
// and returns each command's result during the following frame.
module spi_sensor_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter int          NUM_REGS    = 16,
    parameter logic [7:0]  CHIP_ID     = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_b,
    input  logic        mosi,
    output logic        miso,
    output logic [15:0] rx_cmd,
    output logic        rx_valid,
    output logic        frame_aborted,
    output logic [9:0]  frame_count
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NREG = 7'(NUM_REGS);
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, mosi_sy;
    logic sclk_d, cs_d, sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, last_bit, fresh, exec, abort, addr_ok;
    logic [4:0] bit_cnt;
    logic [15:0] rx_sh, tx_sh, pending, resp;
    logic [1:0] op;
    logic [5:0] addr;
    logic [7:0] data, rd_data;
    logic [7:0] regs [NUM_REGS];
    assign sclk_s    = sclk_sy[SYNC_STAGES-1];
    assign cs_s      = cs_sy[SYNC_STAGES-1];
    assign mosi_s    = mosi_sy[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign last_bit  = sclk_rise && bit_cnt == 5'd15;
    // cs_b synchronizer resets high so an idle bus never looks like a frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sy <= '0;
            cs_sy   <= '1;
            mosi_sy <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
            cs_sy   <= {cs_sy[SYNC_STAGES-2:0], cs_b};
            mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], mosi};
            sclk_d  <= sclk_s;
            cs_d    <= cs_s;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    // the 16th bit wins over a simultaneous cs_b rise; DONE leaves on cs_b level
    always_comb begin
        state_nx = state == IDLE  ? (cs_fall ? SHIFT : IDLE) :
                   state == SHIFT ? (last_bit ? DONE : cs_rise ? IDLE : SHIFT) :
                                    (cs_s ? IDLE : DONE);
    end
    always_comb begin
        miso  = state == SHIFT && tx_sh[15];
        exec  = state == DONE && fresh;
        abort = state == SHIFT && cs_rise && !last_bit && bit_cnt != 5'd0;
    end
    always_comb begin
        op      = rx_sh[15:14];
        addr    = rx_sh[13:8];
        data    = rx_sh[7:0];
        addr_ok = {1'b0, addr} < NREG;
        rd_data = addr_ok ? regs[addr[AW-1:0]] : addr == 6'd63 ? CHIP_ID : 8'h00;
        resp    = op == 2'b00 ? {addr, frame_count} :
                  op == 2'b01 ? 16'h0000 :
                  op == 2'b10 ? {8'h00, rd_data} : {8'hFF, data};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt       <= '0;
            rx_sh         <= '0;
            tx_sh         <= '0;
            pending       <= '0;
            fresh         <= 1'b0;
            rx_cmd        <= '0;
            rx_valid      <= 1'b0;
            frame_aborted <= 1'b0;
            frame_count   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            fresh         <= state != DONE && state_nx == DONE;
            rx_valid      <= exec;
            frame_aborted <= abort;
            if (state == IDLE && cs_fall) begin
                tx_sh   <= pending;
                bit_cnt <= '0;
            end
            if (state == SHIFT && sclk_rise) begin
                rx_sh   <= {rx_sh[14:0], mosi_s};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (state == SHIFT && sclk_fall) tx_sh <= {tx_sh[14:0], 1'b0};
            if (exec) begin
                rx_cmd      <= rx_sh;
                pending     <= resp;
                frame_count <= frame_count + 10'd1;
                if (op == 2'b11 && addr_ok) regs[addr[AW-1:0]] <= data;
            end
        end
    end
endmodule

// File: tb/tb_spi_sensor_responder.sv
// tb_spi_sensor_responder: drives SPI frames and checks responses against a command-level model.
module tb_spi_sensor_responder;
    logic clk = 1'b0, reset = 1'b0, sclk = 1'b0, cs_b = 1'b1, mosi = 1'b0;
    logic miso, rx_valid, frame_aborted;
    logic [15:0] rx_cmd;
    logic [9:0] frame_count;
    int checks = 0, errors = 0, valid_cnt = 0, abort_cnt = 0, half = 8;
    logic [15:0] m_pending, m_cmd;
    logic [9:0] m_fc;
    logic [7:0] m_regs [16];

    spi_sensor_responder dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_b(cs_b), .mosi(mosi),
        .miso(miso), .rx_cmd(rx_cmd), .rx_valid(rx_valid),
        .frame_aborted(frame_aborted), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (frame_aborted) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_pending = 16'h0000;
        m_cmd     = 16'h0000;
        m_fc      = 10'd0;
        foreach (m_regs[i]) m_regs[i] = 8'h00;
    endtask

    // command semantics: result becomes the word shifted out on the next frame
    task automatic model_exec(input logic [15:0] cmd);
        logic [5:0] a;
        logic [15:0] r;
        a = cmd[13:8];
        case (cmd[15:14])
            2'b00:   r = {a, m_fc};
            2'b01:   r = 16'h0000;
            2'b10:   r = a < 6'd16 ? {8'h00, m_regs[a[3:0]]} : a == 6'd63 ? 16'h0001 : 16'h0000;
            default: begin
                if (a < 6'd16) m_regs[a[3:0]] = cmd[7:0];
                r = {8'hFF, cmd[7:0]};
            end
        endcase
        m_pending = r;
        m_cmd     = cmd;
        m_fc      = m_fc + 10'd1;
    endtask

    task automatic shift_bits(input logic [15:0] cmd, input int n, output logic [15:0] got);
        got  = 16'h0000;
        cs_b = 1'b0;
        for (int i = 15; i > 15 - n; i--) begin
            mosi = cmd[i];
            clks(half);
            got  = {got[14:0], miso};
            sclk = 1'b1;
            clks(half);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] cmd, input string tag);
        logic [15:0] got;
        shift_bits(cmd, 16, got);
        clks(half);
        cs_b = 1'b1;
        clks(half);
        chk({tag, " miso"}, got, m_pending);
        model_exec(cmd);
        chk({tag, " rx_cmd"}, rx_cmd, m_cmd);
        chk({tag, " frame_count"}, {6'd0, frame_count}, {6'd0, m_fc});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clks(2);
        reset = 1'b1;
        clks(3);
        model_reset();
    endtask

    initial begin
        logic [15:0] got, cmd;
        int a0, v0;
        model_reset();
        clks(3);
        chk("rst miso", {15'd0, miso}, 16'h0000);
        chk("rst rx_cmd", rx_cmd, 16'h0000);
        chk("rst rx_valid", {15'd0, rx_valid}, 16'h0000);
        chk("rst aborted", {15'd0, frame_aborted}, 16'h0000);
        chk("rst frame_count", {6'd0, frame_count}, 16'h0000);
        reset = 1'b1;
        clks(3);

        frame(16'hC3A5, "wr3");
        frame(16'h8300, "rd3a");
        frame(16'h8300, "rd3b");
        chk("rd3 result", m_pending, 16'h00A5);
        frame(16'hBF00, "rd63");
        frame(16'h4000, "rd63 out");
        frame(16'hFF55, "wr63");
        frame(16'hBF00, "rd63 again");
        frame(16'h4000, "rd63 again out");

        do_reset();
        repeat (5) begin
            cmd = 16'($urandom);
            frame(cmd, "rnd pre-convert");
        end
        frame(16'h0A00, "convert");
        frame(16'h4000, "convert out");

        frame(16'hC012, "wr0");
        a0 = abort_cnt;
        shift_bits(16'h4000, 7, got);
        clks(half);
        cs_b = 1'b1;
        clks(half);
        chk("abort pulses", 16'(abort_cnt - a0), 16'd1);
        chk("abort rx_cmd", rx_cmd, m_cmd);
        chk("abort frame_count", {6'd0, frame_count}, {6'd0, m_fc});
        cs_b = 1'b0;
        clks(half);
        cs_b = 1'b1;
        clks(half);
        chk("empty frame no abort", 16'(abort_cnt - a0), 16'd1);
        frame(16'h4000, "post abort");

        a0 = abort_cnt;
        shift_bits(16'hC1FF, 9, got);
        clks(2);
        reset = 1'b0;
        clks(2);
        chk("midrst miso", {15'd0, miso}, 16'h0000);
        chk("midrst frame_count", {6'd0, frame_count}, 16'h0000);
        chk("midrst rx_cmd", rx_cmd, 16'h0000);
        cs_b = 1'b1;
        clks(half);
        reset = 1'b1;
        clks(half);
        chk("midrst no abort", 16'(abort_cnt - a0), 16'd0);
        model_reset();
        frame(16'h8100, "rd1 after rst");
        frame(16'h4000, "rd1 out");

        repeat (30) begin
            cmd = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cmd[13:8] = 6'd63;
            else if ($urandom_range(0, 1) == 0) cmd[13:8] = 6'($urandom_range(0, 15));
            frame(cmd, "rnd mix");
        end

        do_reset();
        half = 4;
        v0 = valid_cnt;
        repeat (1024) frame(16'h4000, "cal wrap");
        chk("wrap frame_count", {6'd0, frame_count}, 16'h0000);
        chk("wrap rx_valid pulses", 16'(valid_cnt - v0), 16'd1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
